// File: rtl/mem_responder_pkg.sv
// Shared constants and helpers for the 4-byte memory responder.
// The 4B request/response message layouts are defined here as well.
package mem_responder_pkg;

   localparam logic [2:0] MEM_READ  = 3'd0;
   localparam logic [2:0] MEM_WRITE = 3'd1;
   localparam logic [2:0] MEM_INIT  = 3'd2;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   // len 0 encodes a full 4-byte access
   function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
      return (len == 2'd0) ? 3'd4 : {1'b0, len};
   endfunction

   // Lanes past byte 3 fall off the 4-bit result, so accesses never cross words
   function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [1:0] len);
      logic [4:0] span;
      span = (5'd1 << len_to_bytes(len)) - 5'd1;
      return span[3:0] << offset;
   endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// Circular val/rdy FIFO of responses; full/empty derive from the occupancy count.
module mem_responder_fifo
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_depth = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  mem_resp_4B_t                     enq_msg,
   input  logic                             enq_val,
   output logic                             enq_rdy,
   output mem_resp_4B_t                     deq_msg,
   output logic                             deq_val,
   input  logic                             deq_rdy,
   output logic [$clog2(p_depth+1)-1:0]     count
);

   localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int unsigned CW = $clog2(p_depth + 1);

   mem_resp_4B_t   slots [p_depth];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic           enq;
   logic           deq;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PW'(p_depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign enq_rdy = (count != CW'(p_depth));
   assign deq_val = (count != '0);
   assign deq_msg = deq_val ? slots[head] : '0;
   assign enq     = enq_val && enq_rdy;
   assign deq     = deq_val && deq_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= next_ptr(tail);
         if (deq) head <= next_ptr(head);
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) slots[tail] <= enq_msg;
   end

endmodule

// File: rtl/mem_responder_4b.sv
// Memory responder for the 4-byte val/rdy protocol: word array, fixed-latency
// delay line and a credit-checked response FIFO that absorbs backpressure.
module mem_responder_4b
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_mem_words = 256,
   parameter int unsigned p_latency   = 2,
   parameter int unsigned p_buf_depth = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  mem_req_4B_t  req_msg,
   input  logic         req_val,
   output logic         req_rdy,
   output mem_resp_4B_t resp_msg,
   output logic         resp_val,
   input  logic         resp_rdy
);

   localparam int unsigned AW = $clog2(p_mem_words);
   localparam int unsigned CW = $clog2(p_buf_depth + 1);
   localparam int unsigned IW = $clog2(p_buf_depth + p_latency + 1);

   logic [31:0]   mem [p_mem_words];
   logic          req_go;
   logic [AW-1:0] widx;
   logic [1:0]    off;
   logic          is_wr;
   logic [3:0]    be;
   logic [3:0]    rlanes;
   logic [31:0]   wdata_sh;
   logic [31:0]   rmask;
   logic [31:0]   rdata;
   mem_resp_4B_t  acc_resp;

   logic          fifo_in_val;
   mem_resp_4B_t  fifo_in_msg;
   logic          fifo_enq_rdy;
   logic [CW-1:0] fifo_count;
   logic [IW-1:0] dl_busy;
   logic [IW-1:0] inflight;

   assign inflight = dl_busy + IW'(fifo_count);
   assign req_rdy  = rst && (inflight < IW'(p_buf_depth));
   assign req_go   = req_val && req_rdy;

   always_comb begin
      widx     = req_msg.addr[2 +: AW];
      off      = req_msg.addr[1:0];
      is_wr    = (req_msg.type_ == MEM_WRITE) || (req_msg.type_ == MEM_INIT);
      be       = lane_mask(off, req_msg.len);
      rlanes   = lane_mask(2'd0, req_msg.len);
      wdata_sh = req_msg.data << {off, 3'b000};
      rmask    = '0;
      for (int unsigned i = 0; i < 4; i++) rmask[8*i +: 8] = {8{rlanes[i]}};
      rdata    = (mem[widx] >> {off, 3'b000}) & rmask;
      acc_resp        = '0;
      acc_resp.type_  = req_msg.type_;
      acc_resp.opaque = req_msg.opaque;
      acc_resp.len    = req_msg.len;
      acc_resp.data   = is_wr ? '0 : rdata;
   end

   always_ff @(posedge clk) begin
      if (req_go && is_wr) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   // p_latency=1 has no delay stages: the accepted response goes straight into the FIFO
   generate
      if (p_latency > 1) begin : g_dl
         localparam int unsigned N = p_latency - 1;
         logic [N-1:0] v;
         mem_resp_4B_t m [N];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               v <= '0;
            end else begin
               v[0] <= req_go;
               for (int unsigned i = 1; i < N; i++) v[i] <= v[i-1];
            end
         end

         always_ff @(posedge clk) begin
            m[0] <= acc_resp;
            for (int unsigned i = 1; i < N; i++) m[i] <= m[i-1];
         end

         always_comb begin
            dl_busy = '0;
            for (int unsigned i = 0; i < N; i++) dl_busy = dl_busy + IW'(v[i]);
         end

         assign fifo_in_val = v[N-1];
         assign fifo_in_msg = m[N-1];
      end else begin : g_nodl
         assign dl_busy     = '0;
         assign fifo_in_val = req_go;
         assign fifo_in_msg = acc_resp;
      end
   endgenerate

   mem_responder_fifo #(
      .p_depth (p_buf_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .enq_msg (fifo_in_msg),
      .enq_val (fifo_in_val),
      .enq_rdy (fifo_enq_rdy),
      .deq_msg (resp_msg),
      .deq_val (resp_val),
      .deq_rdy (resp_rdy),
      .count   (fifo_count)
   );

   // The delay line cannot stall, so credits must always leave FIFO room
   always_ff @(posedge clk) begin
      if (rst) assert (!fifo_in_val || fifo_enq_rdy);
   end

endmodule

// File: tb/tb_mem_responder_4b.sv
// Directed scoreboard bench for mem_responder_4b (256 words, latency 2, depth 4).
module tb_mem_responder_4b;
   import mem_responder_pkg::*;

   localparam int unsigned MW    = 256;
   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   mem_req_4B_t  req_msg;
   logic         req_val;
   logic         req_rdy;
   mem_resp_4B_t resp_msg;
   logic         resp_val;
   logic         resp_rdy;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   mem_resp_4B_t exp_q [$];
   logic [31:0]  model [MW];
   int           pop_total = 0;
   int           pop_cycle [512];
   logic [31:0]  last_data = '0;
   mem_resp_4B_t held_msg;
   logic         held = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder_4b #(
      .p_mem_words (MW),
      .p_latency   (LAT),
      .p_buf_depth (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_msg  (req_msg),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .resp_msg (resp_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
      end
   endtask

   // Reference model update on acceptance; pushes the expected response
   task automatic accept(input mem_req_4B_t r);
      mem_resp_4B_t e;
      logic [31:0]  w;
      int           idx, off, nb, lane;
      idx = int'((r.addr >> 2) % MW);
      off = int'(r.addr[1:0]);
      nb  = (r.len == 2'd0) ? 4 : int'(r.len);
      w   = model[idx];
      e        = '0;
      e.type_  = r.type_;
      e.opaque = r.opaque;
      e.len    = r.len;
      for (int b = 0; b < nb; b++) begin
         lane = off + b;
         if (lane < 4) begin
            if (r.type_ == MEM_WRITE || r.type_ == MEM_INIT) w[8*lane +: 8] = r.data[8*b +: 8];
            else e.data[8*b +: 8] = w[8*lane +: 8];
         end
      end
      model[idx] = w;
      exp_q.push_back(e);
   endtask

   task automatic mon_step();
      mem_resp_4B_t e;
      if (!rst || !resp_val) begin
         held = 1'b0;
         return;
      end
      if (held) begin
         checks++;
         assert (resp_msg === held_msg) else begin
            errors++;
            $error("FAIL resp_stable obs=%h exp=%h", resp_msg, held_msg);
         end
      end
      if (resp_rdy) begin
         held = 1'b0;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL resp_unexpected obs=%h exp=none", resp_msg);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (resp_msg === e) else begin
               errors++;
               $error("FAIL resp_msg obs=%h exp=%h", resp_msg, e);
            end
            last_data = resp_msg.data;
            pop_cycle[pop_total % 512] = cyc;
            pop_total++;
         end
      end else begin
         held     = 1'b1;
         held_msg = resp_msg;
      end
   endtask

   // Called just after a rising edge; returns just after the acceptance edge
   task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                       input logic [31:0] d, input logic [7:0] o);
      int n = 0;
      req_msg = '{type_: t, opaque: o, addr: a, len: l, data: d};
      req_val = 1'b1;
      @(negedge clk);
      while (!req_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", 64'(req_rdy), 64'd1);
      if (req_rdy) accept(req_msg);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      req_val = 1'b0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      chk("drain_idle", 64'(resp_val), 64'd0);
   endtask

   initial begin
      int acc, c0, p0;
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      rst      = 1'b0;
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      req_msg  = '0;
      #12;
      chk("rst_resp_val", 64'(resp_val), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd0);
      chk("rst_resp_msg", 64'(resp_msg), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_req_rdy", 64'(req_rdy), 64'd1);
      @(posedge clk);
      #1;

      // Basic write then read, with first-response latency
      send(MEM_WRITE, 32'h10, 2'd0, 32'hDEADBEEF, 8'h01);
      req_val = 1'b0;
      @(negedge clk);
      chk("lat_early", 64'(resp_val), 64'd0);
      @(negedge clk);
      chk("lat_first", 64'(resp_val), 64'd1);
      @(posedge clk);
      #1;
      send(MEM_READ, 32'h10, 2'd0, 32'h0, 8'h02);
      drain();
      chk("read_back", 64'(last_data), 64'hDEADBEEF);

      // Sub-word lanes, INIT, lane drop at word end, unknown type as READ
      send(MEM_WRITE, 32'h10, 2'd0, 32'h11223344, 8'h03);
      send(MEM_WRITE, 32'h13, 2'd1, 32'h000000AA, 8'h04);
      send(MEM_READ,  32'h10, 2'd0, 32'h0, 8'h05);
      drain();
      chk("byte_write", 64'(last_data), 64'hAA223344);
      send(MEM_READ,  32'h12, 2'd2, 32'h0, 8'h06);
      drain();
      chk("half_read", 64'(last_data), 64'h0000AA22);
      send(MEM_INIT,  32'h30, 2'd0, 32'h01020304, 8'h08);
      send(MEM_INIT,  32'h32, 2'd2, 32'h0000BEEF, 8'h09);
      send(MEM_WRITE, 32'h34, 2'd0, 32'h55667788, 8'h0A);
      send(MEM_WRITE, 32'h31, 2'd0, 32'hCAFEF00D, 8'h0B);
      send(3'd7,      32'h30, 2'd0, 32'h0, 8'h0C);
      drain();
      chk("lane_drop", 64'(last_data), 64'hFEF00D04);
      send(MEM_READ,  32'h34, 2'd0, 32'h0, 8'h0D);
      drain();
      chk("next_word_intact", 64'(last_data), 64'h55667788);

      // Backpressure: only DEPTH credits, no combinational bypass
      resp_rdy = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         req_msg = '{type_: MEM_READ, opaque: 8'(i), addr: 32'h10, len: 2'd0, data: 32'h0};
         req_val = 1'b1;
         @(negedge clk);
         if (req_rdy) begin
            accept(req_msg);
            acc++;
         end
         @(posedge clk);
         #1;
      end
      req_val = 1'b0;
      chk("bp_accepted", 64'(acc), 64'(DEPTH));
      chk("bp_req_rdy_low", 64'(req_rdy), 64'd0);
      resp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_no_bypass", 64'(req_rdy), 64'd0);
      @(negedge clk);
      chk("bp_credit_back", 64'(req_rdy), 64'd1);
      drain();

      // Full-rate streaming
      for (int i = 0; i < 16; i++)
         send(MEM_WRITE, 32'h100 + 32'(4*i), 2'd0, (32'h01010101 * 32'(i)) ^ 32'hA5A5A5A5, 8'(i));
      drain();
      c0 = cyc;
      p0 = pop_total;
      for (int i = 0; i < 16; i++)
         send(MEM_READ, 32'h100 + 32'(4*i), 2'd0, 32'h0, 8'(8'h40 + i));
      chk("stream_issue", 64'(cyc - c0), 64'd16);
      drain();
      chk("stream_span", 64'(pop_cycle[(p0 + 15) % 512] - pop_cycle[p0 % 512]), 64'd15);

      // Address wrap
      send(MEM_WRITE, 32'h400, 2'd0, 32'h5, 8'h50);
      send(MEM_READ,  32'h0,   2'd0, 32'h0, 8'h51);
      drain();
      chk("addr_wrap", 64'(last_data), 64'h5);

      // Asynchronous reset with responses in flight
      resp_rdy = 1'b0;
      send(MEM_READ, 32'h10,  2'd0, 32'h0, 8'h60);
      send(MEM_READ, 32'h20,  2'd0, 32'h0, 8'h61);
      send(MEM_READ, 32'h100, 2'd0, 32'h0, 8'h62);
      req_val = 1'b0;
      chk("pre_rst_val", 64'(resp_val), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_val", 64'(resp_val), 64'd0);
      chk("async_rst_rdy", 64'(req_rdy), 64'd0);
      chk("async_rst_msg", 64'(resp_msg), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      resp_rdy = 1'b1;
      @(negedge clk);
      chk("rst2_req_rdy", 64'(req_rdy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("no_stale", 64'(resp_val), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send(MEM_READ, 32'h10, 2'd0, 32'h0, 8'h70);
      drain();
      chk("mem_kept", 64'(last_data), 64'hAA223344);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
